ext_arbiter: RTL and testbench
==============================

EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the width of the completed-transaction counter.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req0, input, 1, requester 0 (ID-stage decode) request.
REQ-005 The block SHALL have port a0, input, 5, requester 0 operand.
REQ-006 The block SHALL have port sext0, input, 1, requester 0 sign-extend select (1 = sign, 0 = zero).
REQ-007 The block SHALL have ports req1, a1 and sext1, inputs, widths 1, 5 and 1, carrying requester 1 (bus/LED-segment debug port) equivalents.
REQ-008 The block SHALL have port ext_a, output, 5, operand driven to the shared ext unit.
REQ-009 The block SHALL have port ext_sext, output, 1, sext driven to the shared ext unit.
REQ-010 The block SHALL have port ext_b, input, 32, combinational result from the shared ext unit.
REQ-011 The block SHALL have port gnt, output, 2, one-hot grant (bit i = requester i owns the unit).
REQ-012 The block SHALL have ports done0 and done1, outputs, 1 each, one-cycle completion pulses.
REQ-013 The block SHALL have port result, output, 32, registered extension result.
REQ-014 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 The block SHALL have port txn_cnt, output, CNT_W, count of completed transactions.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-017 In IDLE with any req high at a clock edge, the block SHALL pick a winner, latch its a/sext into internal operand registers, set gnt one-hot to the winner, and enter ISSUE.
REQ-018 With exactly one req high, that requester SHALL win.
REQ-019 With both req high, the requester not granted last SHALL win (round-robin); the last-grant register SHALL reset to 1 so requester 0 wins the first tie.
REQ-020 ext_a and ext_sext SHALL be driven from the latched operand registers, never directly from a0/a1, so changing requester inputs mid-transaction have no effect.
REQ-021 In ISSUE the block SHALL register ext_b into result, keep gnt, and enter RESP at the next edge.
REQ-022 In RESP the block SHALL assert done of the granted requester for exactly one cycle, increment txn_cnt (mod 2^CNT_W, wrapping from all-ones to 0), update last-grant, clear gnt and return to IDLE.
REQ-023 Latency SHALL be: req sampled at edge N, then result valid and done high in the cycle following edge N+2; throughput SHALL be one transaction per 3 cycles.
REQ-024 result SHALL hold its value until the next ISSUE capture.
REQ-025 A requester that drops req after being granted SHALL NOT abort the transaction; done SHALL still pulse.
REQ-026 The block SHALL ignore req in ISSUE and RESP; a req still high on return to IDLE SHALL be treated as a new request and arbitrated normally.
REQ-027 done0 and done1 SHALL never be high in the same cycle, and gnt SHALL never have both bits set.
REQ-028 In IDLE, gnt SHALL be 2'b00 and ext_a/ext_sext SHALL hold their last latched values.

Reset
REQ-029 On rst_n low the block SHALL asynchronously set state IDLE, gnt 2'b00, done0/done1 0, busy 0, result 32'h0, txn_cnt 0, ext_a 5'b0, ext_sext 0, last-grant 1.
REQ-030 Reset asserted mid-transaction SHALL abort it with no done pulse and no txn_cnt increment.
REQ-031 After rst_n deasserts, the first req SHALL be sampled at the first rising clock edge with rst_n high.

Verification
REQ-032 The bench SHALL drive req0=1, a0=5'b11000, sext0=1 alone; the required response is gnt=01, ext_a=11000, done0 pulses once, result=32'hFFFFFFF8, txn_cnt=1.
REQ-033 The bench SHALL drive req1=1, a1=5'b11000, sext1=0 alone; the required response is done1 pulses, result=32'h00000018.
REQ-034 The bench SHALL drive req0 and req1 high together from reset and hold them; the required response is grants alternating 0,1,0,1 with done pulses every 3 cycles.
REQ-035 The bench SHALL change a0 from 5'b11000 to 5'b00001 during ISSUE; the required response is result=32'hFFFFFFF8 (latched operand used).
REQ-036 The bench SHALL pulse rst_n low during ISSUE; the required response is immediate IDLE, gnt=00, no done pulse, txn_cnt unchanged at 0.
REQ-037 The bench SHALL complete 256 transactions with CNT_W=8; the required response is txn_cnt wrapping 8'hFF to 8'h00.

Source files
------------

// File: rtl/ext_arbiter.sv
// -----------------------------------------------------------------------------
// ext_arbiter
//
// Shares one combinational sign/zero-extension unit between two requesters:
// requester 0 (ID-stage decode) and requester 1 (bus / LED-segment debug port).
// Each transaction takes three cycles: IDLE (arbitrate and latch the operand),
// ISSUE (capture the ext unit output), RESP (pulse done, count, release).
//
// Handshake: a requester raises reqN with aN/sextN valid.
// - The request is sampled in IDLE only.
// - The requester may drop reqN or change aN/sextN once gnt[N] is seen, because
//   the operand is latched at the grant edge.
// - doneN pulses for exactly one cycle with result valid.
// - result stays stable until the next transaction captures a new value.
// - A reqN still high after doneN is a new request.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   req0, a0, sext0    : requester 0 request, 5-bit operand, sign-extend select
//   req1, a1, sext1    : requester 1 request, 5-bit operand, sign-extend select
//   ext_a, ext_sext    : operand / select driven to the shared ext unit
//   ext_b              : 32-bit combinational result from the shared ext unit
//   gnt                : one-hot grant (bit i = requester i owns the unit)
//   done0, done1       : one-cycle completion pulses
//   result             : registered extension result
//   busy               : high whenever the FSM is not in IDLE
//   txn_cnt            : completed-transaction counter, wraps mod 2^CNT_W
//   dbg_state          : current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module ext_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [4:0]       a0,
    input  logic             sext0,
    input  logic             req1,
    input  logic [4:0]       a1,
    input  logic             sext1,
    output logic [4:0]       ext_a,
    output logic             ext_sext,
    input  logic [31:0]      ext_b,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [31:0]      result,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [1:0]         gnt_q,     gnt_d;
    logic               owner_q,   owner_d;   // id of the requester being served
    logic               last_q,    last_d;    // id of the last completed grant
    logic [4:0]         op_a_q,    op_a_d;
    logic               op_sext_q, op_sext_d;
    logic [31:0]        result_q,  result_d;
    logic [1:0]         done_q,    done_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;

    // Winner when arbitrating in IDLE. On a tie the requester that did not
    // hold the last grant wins. last_q resets to 1, so requester 0 takes the
    // first tie.
    logic               win_c;
    always_comb begin
        if (req0 && req1) begin
            win_c = ~last_q;
        end else begin
            win_c = req1;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_a_d    = op_a_q;
        op_sext_d = op_sext_q;
        result_d  = result_q;
        done_d    = 2'b00;
        cnt_d     = cnt_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                gnt_d  = 2'b00;
                busy_d = 1'b0;
                if (req0 || req1) begin
                    owner_d   = win_c;
                    op_a_d    = win_c ? a1 : a0;
                    op_sext_d = win_c ? sext1 : sext0;
                    gnt_d     = win_c ? 2'b10 : 2'b01;
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                // ext_b has had the whole cycle to settle on the latched operand.
                result_d = ext_b;
                state_d  = RESP;
            end

            RESP: begin
                done_d  = owner_q ? 2'b10 : 2'b01;
                cnt_d   = cnt_q + CNT_W'(1);
                last_d  = owner_q;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            op_a_q    <= 5'b0;
            op_sext_q <= 1'b0;
            result_q  <= 32'h0;
            done_q    <= 2'b00;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            op_a_q    <= op_a_d;
            op_sext_q <= op_sext_d;
            result_q  <= result_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    // The ext unit only ever sees the latched operand, so requester inputs
    // may change freely once the grant has been taken.
    assign ext_a     = op_a_q;
    assign ext_sext  = op_sext_q;
    assign gnt       = gnt_q;
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign result    = result_q;
    assign busy      = busy_q;
    assign txn_cnt   = cnt_q;
    assign dbg_state = state_q;

    // Structural invariants of the outputs.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q[0] && done_q[1]));
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic [4:0]       a0;
    logic             sext0;
    logic             req1;
    logic [4:0]       a1;
    logic             sext1;
    logic [4:0]       ext_a;
    logic             ext_sext;
    logic [31:0]      ext_b;
    logic [1:0]       gnt;
    logic             done0;
    logic             done1;
    logic [31:0]      result;
    logic             busy;
    logic [CNT_W-1:0] txn_cnt;
    logic [1:0]       dbg_state;

    int n_cmp;
    int n_err;

    ext_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .a0        (a0),
        .sext0     (sext0),
        .req1      (req1),
        .a1        (a1),
        .sext1     (sext1),
        .ext_a     (ext_a),
        .ext_sext  (ext_sext),
        .ext_b     (ext_b),
        .gnt       (gnt),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .busy      (busy),
        .txn_cnt   (txn_cnt),
        .dbg_state (dbg_state)
    );

    // Shared ext unit seen by the arbiter.
    assign ext_b = ext_sext ? {{27{ext_a[4]}}, ext_a} : {27'b0, ext_a};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One transaction at a time: a grant starts it, the result is taken one
    // edge later, and the completion (done, count, last owner) one edge after.
    int          m_left;      // edges remaining in the current transaction
    int          m_owner;
    int          m_last;
    logic [4:0]  m_a;
    logic        m_sext;
    logic [31:0] m_pending;
    logic [31:0] m_result;
    logic        m_done0;
    logic        m_done1;
    int          m_cnt;

    function automatic logic [31:0] extend(input logic [4:0] a, input logic s);
        if (s && a[4]) return 32'hFFFF_FFE0 | 32'(a);
        return 32'(a);
    endfunction

    task automatic m_reset();
        m_left    = 0;
        m_owner   = 0;
        m_last    = 1;
        m_a       = 5'b0;
        m_sext    = 1'b0;
        m_pending = 32'h0;
        m_result  = 32'h0;
        m_done0   = 1'b0;
        m_done1   = 1'b0;
        m_cnt     = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_done0 = 1'b0;
                m_done1 = 1'b0;
                if (m_left == 0) begin
                    if (req0 || req1) begin
                        if (req0 && req1) m_owner = 1 - m_last;
                        else              m_owner = req1 ? 1 : 0;
                        m_a       = (m_owner == 1) ? a1 : a0;
                        m_sext    = (m_owner == 1) ? sext1 : sext0;
                        m_pending = extend(m_a, m_sext);
                        m_left    = 2;
                    end
                end else if (m_left == 2) begin
                    m_result = m_pending;
                    m_left   = 1;
                end else begin
                    if (m_owner == 1) m_done1 = 1'b1;
                    else              m_done0 = 1'b1;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    m_last = m_owner;
                    m_left = 0;
                end
            end
        end
    end

    // Every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("gnt",      32'(gnt),      (m_left == 0) ? 32'd0 : ((m_owner == 1) ? 32'd2 : 32'd1));
            check("busy",     32'(busy),     32'(m_left != 0));
            check("done0",    32'(done0),    32'(m_done0));
            check("done1",    32'(done1),    32'(m_done1));
            check("result",   result,        m_result);
            check("txn_cnt",  32'(txn_cnt),  32'(m_cnt));
            check("ext_a",    32'(ext_a),    32'(m_a));
            check("ext_sext", 32'(ext_sext), 32'(m_sext));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; a0 = 5'b0; sext0 = 1'b0;
        req1 = 1'b0; a1 = 5'b0; sext1 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check("reset_gnt",    32'(gnt),     32'd0);
        check("reset_result", result,       32'h0);
        check("reset_cnt",    32'(txn_cnt), 32'd0);
        rst_n = 1'b1;

        // Reset during ISSUE aborts the transaction.
        req0 = 1'b1; a0 = 5'b11000; sext0 = 1'b1;
        tick();
        check("abort_pre_gnt",  32'(gnt),  32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_gnt",  32'(gnt),     32'd0);
        check("abort_busy", 32'(busy),    32'd0);
        check("abort_done", 32'(done0),   32'd0);
        check("abort_cnt",  32'(txn_cnt), 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("abort_cnt_after", 32'(txn_cnt), 32'd0);

        // Requester 0 alone, sign extension; req dropped after the grant.
        req0 = 1'b1; a0 = 5'b11000; sext0 = 1'b1;
        tick();
        check("r0_gnt",   32'(gnt),   32'd1);
        check("r0_ext_a", 32'(ext_a), 32'b11000);
        req0 = 1'b0; a0 = 5'($urandom_range(0, 31));
        tick();
        tick();
        check("r0_done0",  32'(done0),   32'd1);
        check("r0_result", result,       32'hFFFF_FFF8);
        check("r0_cnt",    32'(txn_cnt), 32'd1);
        tick();
        check("r0_done0_once", 32'(done0), 32'd0);

        // Requester 1 alone, zero extension.
        req1 = 1'b1; a1 = 5'b11000; sext1 = 1'b0;
        tick();
        check("r1_gnt", 32'(gnt), 32'd2);
        req1 = 1'b0;
        tick();
        tick();
        check("r1_done1",  32'(done1),   32'd1);
        check("r1_result", result,       32'h0000_0018);
        check("r1_cnt",    32'(txn_cnt), 32'd2);

        // Operand changed while the transaction is in ISSUE.
        req0 = 1'b1; a0 = 5'b11000; sext0 = 1'b1;
        tick();
        a0 = 5'b00001; req0 = 1'b0;
        tick();
        tick();
        check("latch_done0",  32'(done0),   32'd1);
        check("latch_result", result,       32'hFFFF_FFF8);
        check("latch_cnt",    32'(txn_cnt), 32'd3);

        // Both requesters held from reset: grants alternate 0,1,0,1.
        idle_inputs();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 5'b00101; a1 = 5'b10101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            check("rr_done0", 32'(done0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_done1", 32'(done1), (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        idle_inputs();
        repeat (3) tick();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) != 0) begin
                req0  = ($urandom_range(0, 1) == 1);
                req1  = ($urandom_range(0, 1) == 1);
                a0    = 5'($urandom_range(0, 31));
                a1    = 5'($urandom_range(0, 31));
                sext0 = ($urandom_range(0, 1) == 1);
                sext1 = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        // 256 back-to-back transactions: counter wraps FF -> 00.
        do_reset();
        req0 = 1'b1; a0 = 5'b01111; sext0 = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            tick();
            tick();
            if (k == 255) check("wrap_ff", 32'(txn_cnt), 32'hFF);
            if (k == 256) check("wrap_00", 32'(txn_cnt), 32'h00);
        end
        idle_inputs();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
